// File: rtl/inst_fetch_stage_if.sv
// Fetch-stage bus: redirect/loader controls, instruction memory read port and the
// IF/ID valid/ready handshake toward decode.
interface inst_fetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              load_busy_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic [ADDR_W-1:0] raddr_o;
  logic [INST_W-1:0] rdata_i;
  // IF/ID handshake: an entry transfers on a rising edge where if_valid_o && id_ready_i;
  // while if_valid_o && !id_ready_i the entry (pc, inst, fault) is held unchanged.
  logic              if_valid_o;
  logic              id_ready_i;
  logic [ADDR_W-1:0] if_pc_o;
  logic [INST_W-1:0] if_inst_o;
  logic              if_fault_o;

  modport master (
    input  load_busy_i, redirect_i, redirect_pc_i, rdata_i, id_ready_i,
    output raddr_o, if_valid_o, if_pc_o, if_inst_o, if_fault_o
  );

  modport slave (
    output load_busy_i, redirect_i, redirect_pc_i, rdata_i, id_ready_i,
    input  raddr_o, if_valid_o, if_pc_o, if_inst_o, if_fault_o
  );
endinterface

// File: rtl/inst_fetch_stage.sv
// IF stage: owns the PC, reads the word-indexed instruction memory combinationally
// and captures the returned word into the IF/ID register.
module inst_fetch_stage #(
  parameter int                 ADDR_W    = 32,
  parameter int                 INST_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter int                 MEM_WORDS = 4096,
  parameter logic [INST_W-1:0]  NOP_INST  = 32'h13
) (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_stage_if.master  bus,
  output logic                dbg_state
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [ADDR_W-1:0] MEM_WORDS_W = ADDR_W'(MEM_WORDS);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] word_idx;
  logic              in_range;
  logic              advance;

  assign word_idx    = {2'b00, pc_q[ADDR_W-1:2]};
  assign in_range    = word_idx < MEM_WORDS_W;
  assign bus.raddr_o = word_idx;
  assign dbg_state   = state_q;

  assign advance = (state_q == RUN) && !bus.load_busy_i &&
                   (!bus.if_valid_o || bus.id_ready_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      bus.if_valid_o <= 1'b0;
      bus.if_pc_o    <= '0;
      bus.if_inst_o  <= NOP_INST;
      bus.if_fault_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (!bus.load_busy_i) state_q <= RUN;
        RUN:     if (bus.load_busy_i)  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // Redirect wins over everything, squashing the held entry even if decode took it.
      if (bus.redirect_i) begin
        pc_q           <= {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
        bus.if_valid_o <= 1'b0;
      end else if (advance) begin
        bus.if_valid_o <= 1'b1;
        bus.if_pc_o    <= pc_q;
        pc_q           <= pc_q + ADDR_W'(4);
        if (in_range) begin
          bus.if_inst_o  <= bus.rdata_i;
          bus.if_fault_o <= 1'b0;
        end else begin
          bus.if_inst_o  <= NOP_INST;
          bus.if_fault_o <= 1'b1;
        end
      end else if (bus.if_valid_o && bus.id_ready_i) begin
        bus.if_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Directed bench for inst_fetch_stage: cycle-level reference model checked every
// negedge plus literal expectations for the reset, stall, redirect, loader and fault cases.
module tb_inst_fetch_stage;
  localparam int          MEM_WORDS = 4096;
  localparam logic [31:0] NOP_INST  = 32'h13;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dbg_state;

  inst_fetch_stage_if #(.ADDR_W(32), .INST_W(32)) bus ();

  inst_fetch_stage #(
    .ADDR_W(32), .INST_W(32), .RESET_PC(RESET_PC),
    .MEM_WORDS(MEM_WORDS), .NOP_INST(NOP_INST)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: mem[i] = C0DE_0000 | i; out-of-range reads return junk.
  logic [31:0] mem [0:MEM_WORDS-1];
  assign bus.rdata_i = (bus.raddr_o < 32'(MEM_WORDS)) ? mem[bus.raddr_o[11:0]] : 32'hBAD0_BAD0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch is enabled whenever the loader was idle at the previous edge.
  logic        m_run = 1'b0;
  logic [31:0] m_pc = RESET_PC;
  logic        m_valid = 1'b0;
  logic [31:0] m_ifpc = '0;
  logic [31:0] m_inst = NOP_INST;
  logic        m_fault = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 1'b0; m_pc <= RESET_PC; m_valid <= 1'b0;
      m_ifpc <= '0; m_inst <= NOP_INST; m_fault <= 1'b0;
    end else begin
      m_run <= !bus.load_busy_i;
      if (bus.redirect_i) begin
        m_pc    <= bus.redirect_pc_i & ~32'h3;
        m_valid <= 1'b0;
      end else if (m_run && !bus.load_busy_i && (!m_valid || bus.id_ready_i)) begin
        m_valid <= 1'b1;
        m_ifpc  <= m_pc;
        m_pc    <= m_pc + 32'd4;
        if ((m_pc / 4) < 32'(MEM_WORDS)) begin
          m_inst <= mem[m_pc[13:2]]; m_fault <= 1'b0;
        end else begin
          m_inst <= NOP_INST; m_fault <= 1'b1;
        end
      end else if (m_valid && bus.id_ready_i) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_raddr", bus.raddr_o, m_pc / 4);
    chk("cyc_valid", 32'(bus.if_valid_o), 32'(m_valid));
    chk("cyc_pc", bus.if_pc_o, m_ifpc);
    chk("cyc_inst", bus.if_inst_o, m_inst);
    chk("cyc_fault", 32'(bus.if_fault_o), 32'(m_fault));
    chk("cyc_state", 32'(dbg_state), 32'(m_run));
  end

  // Advance to just after the next falling edge; outputs there reflect the preceding rise.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_entry(input string name, input logic v, input logic [31:0] pc,
                           input logic [31:0] inst, input logic f);
    chk({name, "_valid"}, 32'(bus.if_valid_o), 32'(v));
    if (v) begin
      chk({name, "_pc"}, bus.if_pc_o, pc);
      chk({name, "_inst"}, bus.if_inst_o, inst);
      chk({name, "_fault"}, 32'(bus.if_fault_o), 32'(f));
    end
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_valid"}, 32'(bus.if_valid_o), 32'h0);
    chk({name, "_pc"}, bus.if_pc_o, 32'h0);
    chk({name, "_inst"}, bus.if_inst_o, 32'h13);
    chk({name, "_fault"}, 32'(bus.if_fault_o), 32'h0);
    chk({name, "_raddr"}, bus.raddr_o, 32'h0);
    chk({name, "_state"}, 32'(dbg_state), 32'h0);
  endtask

  localparam logic [15:0] RDY_PAT = 16'b1011_0010_1110_0101;

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'hC0DE_0000 | i;
    bus.load_busy_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = '0;
    bus.id_ready_i = 1'b1;
    #1 rst = 1'b1;
    #2 chk_reset("t0_reset");

    // T1: release reset; first edge enters RUN, second captures word 0.
    tick(); rst = 1'b0;
    tick(); chk("t1_state", 32'(dbg_state), 32'h1); chk("t1_novalid", 32'(bus.if_valid_o), 32'h0);
    tick(); chk_entry("t1_a", 1'b1, 32'h0, 32'hC0DE_0000, 1'b0);
    tick(); chk_entry("t1_b", 1'b1, 32'h4, 32'hC0DE_0001, 1'b0);

    // T2: stall three cycles while holding pc=4.
    bus.id_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_entry("t2_hold", 1'b1, 32'h4, 32'hC0DE_0001, 1'b0);
      chk("t2_raddr", bus.raddr_o, 32'h2);
    end
    bus.id_ready_i = 1'b1;
    tick(); chk_entry("t2_c", 1'b1, 32'h8, 32'hC0DE_0002, 1'b0);

    // T3: redirect with ready low, then a misaligned target.
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h40; bus.id_ready_i = 1'b0;
    tick(); chk("t3_squash", 32'(bus.if_valid_o), 32'h0);
    bus.redirect_i = 1'b0; bus.id_ready_i = 1'b1;
    tick(); chk_entry("t3_tgt", 1'b1, 32'h40, 32'hC0DE_0010, 1'b0);
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h43;
    tick(); chk("t3_squash2", 32'(bus.if_valid_o), 32'h0);
    bus.redirect_i = 1'b0;
    tick(); chk_entry("t3_align", 1'b1, 32'h40, 32'hC0DE_0010, 1'b0);

    // T4: loader busy for five edges; entry held until consumed, then resumes at pc_q.
    bus.load_busy_i = 1'b1; bus.id_ready_i = 1'b0;
    tick(); chk_entry("t4_hold", 1'b1, 32'h40, 32'hC0DE_0010, 1'b0);
    chk("t4_idle", 32'(dbg_state), 32'h0);
    tick(); chk_entry("t4_hold2", 1'b1, 32'h40, 32'hC0DE_0010, 1'b0);
    bus.id_ready_i = 1'b1;
    tick(); chk("t4_consumed", 32'(bus.if_valid_o), 32'h0);
    tick(); chk("t4_nocap", 32'(bus.if_valid_o), 32'h0);
    tick(); chk("t4_nocap2", 32'(bus.if_valid_o), 32'h0);
    bus.load_busy_i = 1'b0;
    tick(); chk("t4_run_nocap", 32'(bus.if_valid_o), 32'h0); chk("t4_run", 32'(dbg_state), 32'h1);
    tick(); chk_entry("t4_resume", 1'b1, 32'h44, 32'hC0DE_0011, 1'b0);

    // T5: last in-range word, then faulting fetches past the end of memory.
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h3FFC;
    tick(); bus.redirect_i = 1'b0;
    tick(); chk_entry("t5_last", 1'b1, 32'h3FFC, 32'hC0DE_0FFF, 1'b0);
    tick(); chk_entry("t5_fault", 1'b1, 32'h4000, 32'h13, 1'b1);
    tick(); chk_entry("t5_fault2", 1'b1, 32'h4004, 32'h13, 1'b1);

    // Mixed ready pattern from a redirect target, checked by the per-cycle model.
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h20;
    tick(); bus.redirect_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.id_ready_i = RDY_PAT[i];
      tick();
    end
    bus.id_ready_i = 1'b1;
    tick();

    // T6: asynchronous reset between edges, then restart as after power-up.
    #2 rst = 1'b1;
    #1 chk_reset("t6_reset");
    tick(); rst = 1'b0;
    tick(); chk("t6_state", 32'(dbg_state), 32'h1); chk("t6_novalid", 32'(bus.if_valid_o), 32'h0);
    tick(); chk_entry("t6_a", 1'b1, 32'h0, 32'hC0DE_0000, 1'b0);
    tick(); chk_entry("t6_b", 1'b1, 32'h4, 32'hC0DE_0001, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
